// File: rtl/column_addr_hamming_enc_pkg.sv
// Shared definitions for the column-address Hamming encoder: code layout and
// the (10,6) encode function used by the encoder and by its checkers.
package column_addr_hamming_enc_pkg;

    localparam int COL_W     = 6;
    localparam int PAR_W     = 4;
    localparam int CODE_W    = COL_W + PAR_W;
    localparam int PAR_LSB   = COL_W;
    localparam int INJ_IDX_W = 4;

    typedef logic [COL_W-1:0]     col_t;
    typedef logic [PAR_W-1:0]     par_t;
    typedef logic [CODE_W-1:0]    code_t;
    typedef logic [INJ_IDX_W-1:0] inj_idx_t;

    // Codeword layout is {p3,p2,p1,p0,d5..d0}; data sits unshifted in the low bits.
    function automatic code_t col_hamming_encode(input col_t d);
        par_t p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5];
        p[2] = d[1] ^ d[2] ^ d[3];
        p[3] = d[4] ^ d[5];
        return {p, d};
    endfunction

endpackage

// File: rtl/column_addr_hamming_enc_fifo.sv
// Generic DEPTH x DATA_W synchronous FIFO with valid/ready on both sides.
// A pop frees a slot in the same cycle; there is no write-to-read bypass.
module col_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              full, empty, push, pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        wr_ready = !full || rd_ready;
        rd_valid = !empty;
        push     = wr_valid && wr_ready;
        pop      = rd_valid && rd_ready;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        // Empty head reads as zero so storage need not be reset.
        rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/column_addr_hamming_enc.sv
// End-of-column event front end: range-checks the column address, Hamming-encodes
// it, optionally flips one codeword bit for decoder testing, and queues the event.
module column_addr_hamming_enc
    import column_addr_hamming_enc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PLD_W   = 8,
    parameter int MAX_COL = 39
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COL_W-1:0]  in_col,
    input  logic [PLD_W-1:0]  in_pld,
    input  logic              inj_en,
    input  logic [3:0]        inj_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [PLD_W-1:0]  out_pld,
    output logic              overflow,
    output logic [7:0]        bad_col_cnt
);

    localparam int   ENT_W     = CODE_W + PLD_W;
    localparam col_t MAX_COL_V = COL_W'(MAX_COL);
    localparam inj_idx_t LAST_BIT = INJ_IDX_W'(CODE_W - 1);

    logic       col_legal, accept, push;
    logic       fifo_wr_valid, fifo_wr_ready;
    code_t      code_raw, flip_mask, code_wr;
    logic [ENT_W-1:0] fifo_wr_data, fifo_rd_data;

    logic       inj_pend_q, inj_pend_d;
    inj_idx_t   inj_idx_q, inj_idx_d;
    logic       overflow_q, overflow_d;
    logic [7:0] bad_cnt_q, bad_cnt_d;

    always_comb begin
        col_legal     = (in_col <= MAX_COL_V);
        accept        = in_valid && in_ready;
        fifo_wr_valid = in_valid && col_legal;
        push          = fifo_wr_valid && fifo_wr_ready;
        code_raw      = col_hamming_encode(in_col);
        // An out-of-range index still consumes the pending request, flipping nothing.
        flip_mask     = (inj_pend_q && (inj_idx_q <= LAST_BIT)) ? (CODE_W'(1) << inj_idx_q) : '0;
        code_wr       = code_raw ^ flip_mask;
        fifo_wr_data  = {code_wr, in_pld};
    end

    always_comb begin
        inj_pend_d = inj_pend_q;
        inj_idx_d  = inj_idx_q;
        if (push) begin
            inj_pend_d = 1'b0;
        end
        // A fresh request wins over one consumed in the same cycle.
        if (inj_en) begin
            inj_pend_d = 1'b1;
            inj_idx_d  = inj_bit;
        end
        overflow_d = overflow_q || (in_valid && !in_ready);
        bad_cnt_d  = bad_cnt_q;
        if (accept && !col_legal && (bad_cnt_q != 8'hFF)) begin
            bad_cnt_d = bad_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pend_q <= 1'b0;
            inj_idx_q  <= '0;
            overflow_q <= 1'b0;
            bad_cnt_q  <= '0;
        end else begin
            inj_pend_q <= inj_pend_d;
            inj_idx_q  <= inj_idx_d;
            overflow_q <= overflow_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    col_event_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (fifo_wr_valid),
        .wr_ready (fifo_wr_ready),
        .wr_data  (fifo_wr_data),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (fifo_rd_data)
    );

    always_comb begin
        in_ready    = fifo_wr_ready;
        out_code    = fifo_rd_data[ENT_W-1:PLD_W];
        out_pld     = fifo_rd_data[PLD_W-1:0];
        overflow    = overflow_q;
        bad_col_cnt = bad_cnt_q;
    end

endmodule

// File: tb/tb_column_addr_hamming_enc.sv
// Directed-vector bench for column_addr_hamming_enc: encoding table, streaming,
// back-pressure, range drop, bit injection and asynchronous reset.
module tb_column_addr_hamming_enc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [5:0] in_col;
    logic [7:0] in_pld;
    logic       inj_en;
    logic [3:0] inj_bit;
    logic       out_valid, out_ready;
    logic [9:0] out_code;
    logic [7:0] out_pld;
    logic       overflow;
    logic [7:0] bad_col_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    column_addr_hamming_enc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_col      (in_col),
        .in_pld      (in_pld),
        .inj_en      (inj_en),
        .inj_bit     (inj_bit),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_pld     (out_pld),
        .overflow    (overflow),
        .bad_col_cnt (bad_col_cnt)
    );

    typedef struct {
        logic [5:0] col;
        logic [7:0] pld;
        logic [9:0] code;
    } vec_t;

    // Independent reference: parity groups expressed as data masks.
    function automatic logic [9:0] ref_enc(input logic [5:0] c);
        logic [3:0] p;
        p[0] = ^(c & 6'b011011);
        p[1] = ^(c & 6'b101101);
        p[2] = ^(c & 6'b001110);
        p[3] = ^(c & 6'b110000);
        return {p, c};
    endfunction

    // Minimal single-error-correcting decoder as the downstream stage would apply it.
    function automatic logic [5:0] ref_dec(input logic [9:0] cw);
        logic [3:0] s;
        logic [5:0] d;
        d = cw[5:0];
        s = ref_enc(d) >> 6;
        s = s ^ cw[9:6];
        case (s)
            4'b0011: d[0] = ~d[0];
            4'b0101: d[1] = ~d[1];
            4'b0110: d[2] = ~d[2];
            4'b0111: d[3] = ~d[3];
            4'b1001: d[4] = ~d[4];
            4'b1010: d[5] = ~d[5];
            default: ;
        endcase
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_one(input logic [5:0] c, input logic [7:0] p);
        in_valid = 1'b1;
        in_col   = c;
        in_pld   = p;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic inj_pulse(input logic [3:0] b);
        inj_en  = 1'b1;
        inj_bit = b;
        @(negedge clk);
        inj_en  = 1'b0;
    endtask

    task automatic push_expect(input string name, input logic [5:0] c, input logic [9:0] exp);
        push_one(c, 8'hA5);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_code"}, 32'(out_code), 32'(exp));
        @(negedge clk);
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{6'd0,  8'h00, 10'h000};
        vecs[1] = '{6'd5,  8'h12, 10'h145};
        vecs[2] = '{6'd9,  8'h34, 10'h109};
        vecs[3] = '{6'd39, 8'h56, 10'h2A7};
        vecs[4] = '{6'd7,  8'h78, 10'h007};
        vecs[5] = '{6'd8,  8'h9A, 10'h1C8};
        vecs[6] = '{6'd16, 8'hBC, 10'h250};
        vecs[7] = '{6'd32, 8'hDE, 10'h2A0};
        vecs[8] = '{6'd1,  8'hF0, 10'h0C1};
        vecs[9] = '{6'd2,  8'h0F, 10'h142};

        rst_n = 1'b0; in_valid = 1'b0; in_col = '0; in_pld = '0;
        inj_en = 1'b0; inj_bit = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_out_pld", 32'(out_pld), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_bad_cnt", 32'(bad_col_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Hand-computed table, one event at a time through an empty FIFO.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_one(vecs[i].col, vecs[i].pld);
            check("tbl_valid", 32'(out_valid), 32'd1);
            check("tbl_code", 32'(out_code), 32'(vecs[i].code));
            check("tbl_pld", 32'(out_pld), 32'(vecs[i].pld));
            check("tbl_model", 32'(ref_enc(vecs[i].col)), 32'(vecs[i].code));
            @(negedge clk);
            check("tbl_drained", 32'(out_valid), 32'd0);
        end

        // Back-to-back stream of every legal column, one per cycle.
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) begin
                check("sweep_valid", 32'(out_valid), 32'd1);
                check("sweep_code", 32'(out_code), 32'(ref_enc(6'(c - 1))));
                check("sweep_pld", 32'(out_pld), 32'((c - 1) * 3) & 32'hFF);
            end
            if (c < 40) begin
                in_valid = 1'b1; in_col = 6'(c); in_pld = 8'(c * 3);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("sweep_end_empty", 32'(out_valid), 32'd0);

        // Out-of-range columns are accepted but dropped and counted.
        push_one(6'd40, 8'h01);
        check("bad40_ready", 32'(in_ready), 32'd1);
        check("bad40_valid", 32'(out_valid), 32'd0);
        push_one(6'd63, 8'h02);
        check("bad63_valid", 32'(out_valid), 32'd0);
        check("bad_cnt2", 32'(bad_col_cnt), 32'd2);
        in_valid = 1'b1; in_col = 6'd50;
        repeat (298) @(negedge clk);
        in_valid = 1'b0;
        check("bad_cnt_sat", 32'(bad_col_cnt), 32'd255);
        check("bad_none_out", 32'(out_valid), 32'd0);
        push_one(6'd41, 8'h03);
        check("bad_cnt_hold", 32'(bad_col_cnt), 32'd255);

        // Bit injection.
        inj_pulse(4'd3);
        push_one(6'd9, 8'h44);
        check("inj3_code", 32'(out_code), 32'h101);
        check("inj3_decoded", 32'(ref_dec(out_code)), 32'd9);
        @(negedge clk);
        push_expect("inj_cleared", 6'd9, 10'h109);
        inj_pulse(4'd12);
        push_expect("inj12", 6'd9, 10'h109);
        push_expect("inj12_after", 6'd5, 10'h145);
        inj_pulse(4'd9);
        push_expect("inj9", 6'd5, 10'h345);
        inj_pulse(4'd2);
        inj_pulse(4'd7);
        push_expect("inj_overwrite", 6'd0, 10'h080);
        inj_pulse(4'd0);
        push_one(6'd50, 8'h00);
        check("inj_skip_bad", 32'(out_valid), 32'd0);
        push_expect("inj_after_bad", 6'd0, 10'h001);

        // Back-pressure: fill, overflow, simultaneous push/pop, drain.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_col = 6'(k); in_pld = 8'(k * 17);
            @(negedge clk);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head_code", 32'(out_code), 32'(ref_enc(6'd1)));
        check("full_no_ovf_yet", 32'(overflow), 32'd0);
        in_col = 6'd5; in_pld = 8'd85;
        @(negedge clk);
        check("overflow_set", 32'(overflow), 32'd1);
        check("hold_code", 32'(out_code), 32'(ref_enc(6'd1)));
        @(negedge clk);
        check("hold_code2", 32'(out_code), 32'(ref_enc(6'd1)));
        check("hold_pld2", 32'(out_pld), 32'd17);
        out_ready = 1'b1;
        #1;
        check("full_pop_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("still_full", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_code", 32'(out_code), 32'(ref_enc(6'(k))));
            check("drain_pld", 32'(out_pld), 32'(k * 17));
            @(negedge clk);
        end
        check("drain_empty", 32'(out_valid), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Asynchronous reset with entries queued.
        out_ready = 1'b0;
        push_one(6'd10, 8'h0A);
        push_one(6'd11, 8'h0B);
        push_one(6'd12, 8'h0C);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_code", 32'(out_code), 32'd0);
        check("arst_bad_cnt", 32'(bad_col_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        push_one(6'd20, 8'h20);
        check("post_rst_code", 32'(out_code), 32'(ref_enc(6'd20)));
        check("post_rst_pld", 32'(out_pld), 32'h20);
        @(negedge clk);
        check("post_rst_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
